// File: rtl/multi16_unsigned_pipe.sv
// 16x16 unsigned multiplier, three pipeline stages behind an operand register.
// Stage 1 forms four 8x8 partial products. Stage 2 compresses the three
// middle-weight terms with a carry-save adder. Stage 3 does the single
// carry-propagate add and registers the 32-bit product.
module multi16_unsigned_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] prod
);

    // 3:2 compressor over 16-bit words; result is {carry, sum}
    function automatic logic [31:0] csa16(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z
    );
        logic [15:0] s;
        logic [15:0] c;
        s = x ^ y ^ z;
        c = (x & y) | (x & z) | (y & z);
        return {c, s};
    endfunction

    // operand registers
    logic [15:0] a_r;
    logic [15:0] b_r;

    // stage 1: partial products
    logic [15:0] ll_r;
    logic [15:0] hl_r;
    logic [15:0] lh_r;
    logic [15:0] hh_r;

    // stage 2: carry-save vectors plus the bytes that bypass the adder
    logic [15:0] s_r;
    logic [15:0] c_r;
    logic [7:0]  hh_hi_r;
    logic [7:0]  ll_lo_r;

    // combinational helpers
    logic [15:0] ll_s;
    logic [15:0] hl_s;
    logic [15:0] lh_s;
    logic [15:0] hh_s;
    logic [31:0] csa_s;
    logic [23:0] upper_s;

    // 8x8 partial products from the held operands, and the CSA/final-add terms
    always_comb begin
        ll_s    = {8'd0, a_r[7:0]}  * {8'd0, b_r[7:0]};
        hl_s    = {8'd0, a_r[15:8]} * {8'd0, b_r[7:0]};
        lh_s    = {8'd0, a_r[7:0]}  * {8'd0, b_r[15:8]};
        hh_s    = {8'd0, a_r[15:8]} * {8'd0, b_r[15:8]};
        csa_s   = csa16(hl_r, {hh_r[7:0], ll_r[15:8]}, lh_r);
        // the carry out of bit 23 is always zero for 16x16 operands
        upper_s = {hh_hi_r, s_r} + {7'd0, c_r, 1'b0};
    end

    // capture operands on load; hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= 16'd0;
            b_r <= 16'd0;
        end else if (load) begin
            a_r <= a;
            b_r <= b;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    // stage 1: register the four partial products every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ll_r <= 16'd0;
            hl_r <= 16'd0;
            lh_r <= 16'd0;
            hh_r <= 16'd0;
        end else begin
            ll_r <= ll_s;
            hl_r <= hl_s;
            lh_r <= lh_s;
            hh_r <= hh_s;
        end
    end

    // stage 2: register carry-save sum/carry and the pass-through bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r     <= 16'd0;
            c_r     <= 16'd0;
            hh_hi_r <= 8'd0;
            ll_lo_r <= 8'd0;
        end else begin
            s_r     <= csa_s[15:0];
            c_r     <= csa_s[31:16];
            hh_hi_r <= hh_r[15:8];
            ll_lo_r <= ll_r[7:0];
        end
    end

    // stage 3: final carry-propagate add into the registered product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= 32'd0;
        end else begin
            prod <= {upper_s, ll_lo_r};
        end
    end

endmodule

// File: tb/tb_multi16_unsigned_pipe.sv
// Self-checking bench for multi16_unsigned_pipe: an arithmetic latency model
// checked every cycle, plus hand-computed literal products.
module tb_multi16_unsigned_pipe;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        load = 1'b0;
    logic [15:0] a    = 16'd0;
    logic [15:0] b    = 16'd0;
    logic [31:0] prod;

    int n_vec = 0;
    int n_err = 0;

    multi16_unsigned_pipe dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .a    (a),
        .b    (b),
        .prod (prod)
    );

    always #50 clk = ~clk;

    // model: operands held by load; product appears 3 edges after capture
    logic [15:0] am = 16'd0;
    logic [15:0] bm = 16'd0;
    logic [31:0] q0 = 32'd0;
    logic [31:0] q1 = 32'd0;
    logic [31:0] q2 = 32'd0;
    logic [31:0] q3 = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            am <= 16'd0; bm <= 16'd0;
            q0 <= 32'd0; q1 <= 32'd0; q2 <= 32'd0; q3 <= 32'd0;
        end else begin
            if (load) begin
                am <= a;
                bm <= b;
                q0 <= 32'(a) * 32'(b);
            end else begin
                q0 <= 32'(am) * 32'(bm);
            end
            q1 <= q0;
            q2 <= q1;
            q3 <= q2;
        end
    end

    // per-cycle compare against the model, well after the active edge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            n_vec = n_vec + 1;
            if (prod !== q3) begin
                n_err = n_err + 1;
                $display("FAIL model t=%0t prod=%0d expected=%0d", $time, prod, q3);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (prod !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s t=%0t prod=%0d expected=%0d", name, $time, prod, exp);
        end
    endtask

    // one-edge load pulse, then wait to E0+3 and check the literal product
    task automatic do_vec(input string name, input logic [15:0] va,
                          input logic [15:0] vb, input logic [31:0] exp);
        @(negedge clk);
        a = va; b = vb; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;   // must not affect anything
        @(negedge clk);
        a = 16'h1234; b = 16'h5678;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_lit(name, exp);
    endtask

    initial begin
        #1  rst = 1'b1;
        #59 rst = 1'b0;

        // first load at the t=150 edge, product at t=450
        do_vec("v3829x2937", 16'd3829, 16'd2937, 32'd11245773);

        // load at the t=750 edge
        @(negedge clk);                  // t=600
        @(negedge clk);                  // t=700
        a = 16'hFF80; b = 16'h01C0; load = 1'b1;
        @(negedge clk);                  // t=800
        load = 1'b0;
        @(negedge clk); #1;              // after t=850 edge
        check_lit("hold850", 32'd11245773);
        @(negedge clk); #1;              // after t=950 edge
        check_lit("hold950", 32'd11245773);
        @(negedge clk); #1;              // after t=1050 edge
        check_lit("ff80x01c0", 32'd29302784);

        do_vec("ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        do_vec("250x250",   16'd250,  16'd250,  32'd62500);
        do_vec("aaaax5555", 16'hAAAA, 16'h5555, 32'd954408050);
        do_vec("5500x0",    16'd5500, 16'd0,    32'd0);
        do_vec("7123x1",    16'd7123, 16'd1,    32'd7123);

        // reset one cycle after a load discards the in-flight product
        @(negedge clk);
        a = 16'd1000; b = 16'd1000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        #20 rst = 1'b1;
        #1 check_lit("rst_immediate", 32'd0);
        @(negedge clk);
        load = 1'b1; a = 16'd77; b = 16'd77;   // ignored while in reset
        @(negedge clk);
        load = 1'b0;
        #20 rst = 1'b0;
        repeat (5) @(negedge clk);
        #1 check_lit("rst_stays0", 32'd0);

        // back-to-back loads
        @(negedge clk);
        a = 16'd300; b = 16'd400; load = 1'b1;
        @(negedge clk);
        a = 16'd65535; b = 16'd2; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check_lit("b2b_first", 32'd120000);
        @(negedge clk); #1;
        check_lit("b2b_second", 32'd131070);

        repeat (4) @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
